// File: rtl/instr_issue_unit.sv
// Push-button instruction issue stage: synchronises and debounces CENTER, captures SW on
// each clean press and offers it to the core over a valid/ready handshake.
module instr_issue_unit #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic        CLK100MHZ,
   input  logic        RESET,
   input  logic        CENTER,
   input  logic [15:0] SW,
   input  logic        INSTR_READY,
   output logic [15:0] INSTR,
   output logic        INSTR_VALID,
   output logic        BUSY,
   output logic [7:0]  ISSUE_COUNT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_meta_p0;
   logic             btn_sync_p1;
   logic             btn_stable;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             press;

   state_t           state_q, state_d;
   logic [15:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic [7:0]       count_q, count_d;

   // Stage p0 -> p1: two-flop synchroniser on the raw button, nothing ahead of it
   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         btn_meta_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
      end else begin
         btn_meta_p0 <= CENTER;
         btn_sync_p1 <= btn_meta_p0;
      end
   end

   // A level change is accepted only after it has persisted for DEBOUNCE_CYCLES cycles.
   // press fires on the very edge where btn_stable goes 0 -> 1, so capture lines up with it.
   assign accept = (btn_sync_p1 != btn_stable) && (cnt == CNT_LAST);
   assign press  = accept && btn_sync_p1;

   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         btn_stable <= 1'b0;
         cnt        <= '0;
      end else if (btn_sync_p1 == btn_stable) begin
         cnt <= '0;
      end else if (accept) begin
         btn_stable <= btn_sync_p1;
         cnt        <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = valid_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (press) begin
               instr_d = SW;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (INSTR_READY) begin
               valid_d = 1'b0;
               count_d = count_q + 8'd1;
               state_d = btn_stable ? RELEASE : IDLE;
            end
         end
         RELEASE: begin
            if (!btn_stable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         state_q <= IDLE;
         instr_q <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign INSTR       = instr_q;
   assign INSTR_VALID = valid_q;
   assign ISSUE_COUNT = count_q;
   assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit with a short debounce window (4 cycles).
module tb_instr_issue_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        center;
   logic [15:0] sw;
   logic        ready;
   logic [15:0] instr;
   logic        instr_valid;
   logic        busy;
   logic [7:0]  issue_count;

   int checks = 0;
   int errors = 0;

   instr_issue_unit #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .CLK100MHZ  (clk),
      .RESET      (rst),
      .CENTER     (center),
      .SW         (sw),
      .INSTR_READY(ready),
      .INSTR      (instr),
      .INSTR_VALID(instr_valid),
      .BUSY       (busy),
      .ISSUE_COUNT(issue_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      center = 1'b0;
      ready  = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic press_release();
      center = 1'b1;
      tick(10);
      center = 1'b0;
      tick(10);
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      center = 1'b1;
      ready  = 1'b0;
      sw     = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (instr !== 16'h0000 || instr_valid !== 1'b0 || busy !== 1'b0 || issue_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state cycle %0d: instr=%h valid=%b busy=%b count=%0d, required 0000/0/0/0",
                     i, instr, instr_valid, busy, issue_count);
         end
      end
      center = 1'b0;
      rst    = 1'b0;
      tick(8);
      checks++;
      if (instr_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: valid=%b busy=%b, required 0/0", instr_valid, busy);
      end
   endtask

   task automatic test_single_issue();
      int nvalid = 0;
      int first  = 0;
      ready  = 1'b1;
      sw     = 16'h8008;
      center = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 20) center = 1'b0;
         if (instr_valid === 1'b1) begin
            nvalid++;
            if (first == 0) first = i;
            checks++;
            if (instr !== 16'h8008) begin
               errors++;
               $display("FAIL single_instr: got %h, required 8008", instr);
            end
         end
      end
      checks++;
      if (nvalid != 1) begin
         errors++;
         $display("FAIL single_valid_cycles: got %0d, required 1", nvalid);
      end
      checks++;
      if (first != 6) begin
         errors++;
         $display("FAIL single_latency: got %0d, required 6", first);
      end
      checks++;
      if (issue_count !== 8'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_count: count=%0d busy=%b, required 1/0", issue_count, busy);
      end
      ready = 1'b0;
   endtask

   task automatic test_bounce();
      int seen = 0;
      do_reset();
      ready = 1'b1;
      sw    = 16'h1234;
      for (int i = 0; i < 25; i++) begin
         center = (i < 5) ? ~i[0] : 1'b0;
         tick();
         if (instr_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL bounce_no_issue: %0d active cycles, required 0", seen);
      end
      checks++;
      if (issue_count !== 8'd0) begin
         errors++;
         $display("FAIL bounce_count: got %0d, required 0", issue_count);
      end
      ready = 1'b0;
   endtask

   task automatic test_ready_wait();
      do_reset();
      ready  = 1'b0;
      sw     = 16'h8104;
      center = 1'b1;
      tick(6);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h8104) begin
         errors++;
         $display("FAIL wait_capture: valid=%b instr=%h, required 1/8104", instr_valid, instr);
      end
      sw = 16'h0201;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (instr_valid !== 1'b1 || instr !== 16'h8104 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_hold cycle %0d: valid=%b instr=%h busy=%b, required 1/8104/1",
                     i, instr_valid, instr, busy);
         end
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || issue_count !== 8'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL wait_handshake: valid=%b count=%0d busy=%b, required 0/1/1",
                  instr_valid, issue_count, busy);
      end
      center = 1'b0;
      tick(10);
      checks++;
      if (busy !== 1'b0 || instr !== 16'h8104 || issue_count !== 8'd1) begin
         errors++;
         $display("FAIL wait_release: busy=%b instr=%h count=%0d, required 0/8104/1",
                  busy, instr, issue_count);
      end
   endtask

   task automatic test_press_in_issue();
      int extra = 0;
      do_reset();
      ready  = 1'b0;
      sw     = 16'h1111;
      center = 1'b1;
      tick(6);
      center = 1'b0;
      sw     = 16'h2222;
      tick(8);
      center = 1'b1;
      tick(8);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h1111) begin
         errors++;
         $display("FAIL second_press_recapture: valid=%b instr=%h, required 1/1111", instr_valid, instr);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || issue_count !== 8'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL second_press_handshake: valid=%b count=%0d busy=%b, required 0/1/1",
                  instr_valid, issue_count, busy);
      end
      center = 1'b0;
      ready  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (instr_valid !== 1'b0) extra++;
      end
      ready = 1'b0;
      checks++;
      if (extra != 0 || issue_count !== 8'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL second_press_dropped: extra=%0d count=%0d busy=%b, required 0/1/0",
                  extra, issue_count, busy);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      ready = 1'b1;
      sw    = 16'h0F0F;
      for (int i = 0; i < 255; i++) press_release();
      checks++;
      if (issue_count !== 8'd255) begin
         errors++;
         $display("FAIL wrap_255: got %0d, required 255", issue_count);
      end
      press_release();
      checks++;
      if (issue_count !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_0: count=%0d busy=%b, required 0/0", issue_count, busy);
      end
      ready = 1'b0;
   endtask

   task automatic test_reset_mid_issue();
      int lat = 0;
      do_reset();
      ready  = 1'b0;
      sw     = 16'hA5C3;
      center = 1'b1;
      tick(6);
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup: valid=%b, required 1", instr_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || busy !== 1'b0 || issue_count !== 8'd0 || instr !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_clear: valid=%b busy=%b count=%0d instr=%h, required 0/0/0/0000",
                  instr_valid, busy, issue_count, instr);
      end
      sw = 16'h3C5A;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         if (instr_valid === 1'b1) lat = i;
      end
      checks++;
      if (lat != 6 || instr !== 16'h3C5A) begin
         errors++;
         $display("FAIL midreset_repress: latency=%0d instr=%h, required 6/3c5a", lat, instr);
      end
      ready = 1'b1;
      tick();
      ready  = 1'b0;
      center = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || issue_count !== 8'd1) begin
         errors++;
         $display("FAIL midreset_issue: valid=%b count=%0d, required 0/1", instr_valid, issue_count);
      end
      tick(10);
   endtask

   initial begin
      rst    = 1'b0;
      center = 1'b0;
      sw     = '0;
      ready  = 1'b0;
      tick();
      test_reset();
      test_single_issue();
      test_bounce();
      test_ready_wait();
      test_press_in_issue();
      test_wrap();
      test_reset_mid_issue();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
